// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
//   N-digit BCD up/down counter with per-digit ripple enables, parallel load,
//   direction control and a wrap/saturate mode at terminal count.
//
// Parameters
//   DIGITS   number of BCD digits (>= 2)
//   WRAP     1: roll over at terminal count, 0: hold at terminal count
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   en        in   count enable for digit 0
//   up        in   1 = count up, 0 = count down
//   load      in   synchronous parallel load (beats en)
//   load_val  in   BCD load value, digit i at [4i+3:4i]
//   q         out  registered BCD count, digit 0 least significant
//   ena       out  ena[i-1] = digit i steps this cycle (combinational)
//   ovf       out  registered pulse: terminal-count event on the last edge
//   bad_load  out  registered pulse: last load carried a nibble > 9
// -----------------------------------------------------------------------------
module bcd_counter_n #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic [DIGITS-2:0]   ena,
    output logic                ovf,
    output logic                bad_load
);

    // Up step of one BCD digit: 9 rolls to 0.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        if (d >= 4'd9) begin
            return 4'd0;
        end else begin
            return d + 4'd1;
        end
    endfunction

    // Down step of one BCD digit: 0 rolls to 9.
    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        if (d == 4'd0) begin
            return 4'd9;
        end else if (d > 4'd9) begin
            return 4'd9;
        end else begin
            return d - 4'd1;
        end
    endfunction

    // Replace a non-decimal nibble by zero.
    function automatic logic [3:0] bcd_clean(input logic [3:0] d);
        if (d > 4'd9) begin
            return 4'd0;
        end else begin
            return d;
        end
    endfunction

    logic [4*DIGITS-1:0] r_q;
    logic                r_ovf;
    logic                r_bad_load;

    logic [DIGITS-1:0]   w_run9;     // all digits below i are 9
    logic [DIGITS-1:0]   w_run0;     // all digits below i are 0
    logic                w_all9;
    logic                w_all0;
    logic                w_term;
    logic                w_sat;      // saturating hold at terminal count
    logic [DIGITS-1:0]   w_step;
    logic [4*DIGITS-1:0] w_next_q;
    logic [4*DIGITS-1:0] w_load_q;
    logic                w_load_bad;

    // Ripple-carry prefix of "lower digits at 9 / at 0" for every digit.
    always_comb begin
        logic v_a9;
        logic v_a0;
        v_a9   = 1'b1;
        v_a0   = 1'b1;
        w_run9 = '0;
        w_run0 = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_run9[i] = v_a9;
            w_run0[i] = v_a0;
            v_a9 = v_a9 & (r_q[4*i +: 4] == 4'd9);
            v_a0 = v_a0 & (r_q[4*i +: 4] == 4'd0);
        end
        w_all9 = v_a9;
        w_all0 = v_a0;
    end

    // Terminal count, per-digit step decisions and the next count value.
    always_comb begin
        w_term   = up ? w_all9 : w_all0;
        w_sat    = en & w_term & (WRAP == 1'b0);
        w_step   = '0;
        w_next_q = r_q;
        for (int i = 0; i < DIGITS; i++) begin
            w_step[i] = en & ~w_sat & (up ? w_run9[i] : w_run0[i]);
            if (w_step[i]) begin
                w_next_q[4*i +: 4] = up ? bcd_inc(r_q[4*i +: 4]) : bcd_dec(r_q[4*i +: 4]);
            end else begin
                w_next_q[4*i +: 4] = r_q[4*i +: 4];
            end
        end
    end

    // Sanitised load value and detection of non-decimal nibbles.
    always_comb begin
        w_load_q   = '0;
        w_load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load_q[4*i +: 4] = bcd_clean(load_val[4*i +: 4]);
            w_load_bad         = w_load_bad | (load_val[4*i +: 4] > 4'd9);
        end
    end

    // Ripple enables for digits 1..DIGITS-1; suppressed whenever the edge is
    // a reset or load so downstream logic never sees a phantom step.
    always_comb begin
        if (reset || load) begin
            ena = '0;
        end else begin
            ena = w_step[DIGITS-1:1];
        end
    end

    // State registers: reset beats load beats counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q        <= '0;
            r_ovf      <= 1'b0;
            r_bad_load <= 1'b0;
        end else if (load) begin
            r_q        <= w_load_q;
            r_ovf      <= 1'b0;
            r_bad_load <= w_load_bad;
        end else begin
            r_q        <= w_next_q;
            r_ovf      <= en & w_term;
            r_bad_load <= 1'b0;
        end
    end

    assign q        = r_q;
    assign ovf      = r_ovf;
    assign bad_load = r_bad_load;

endmodule

// File: tb/tb_bcd_counter_n.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_n
//   Three counter instances (4 digits wrap, 4 digits saturate, 6 digits wrap)
//   share one stimulus stream. A decimal model predicts each instance; the
//   stimulus process queues the expectations and a monitor compares them.
// -----------------------------------------------------------------------------
module tb_bcd_counter_n;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [23:0] load_val = 24'd0;

    logic [15:0] q_a, q_b;
    logic [23:0] q_c;
    logic [2:0]  ena_a, ena_b;
    logic [4:0]  ena_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        bad_a, bad_b, bad_c;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val[15:0]), .q(q_a), .ena(ena_a), .ovf(ovf_a), .bad_load(bad_a));

    bcd_counter_n #(.DIGITS(4), .WRAP(1'b0)) u_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val[15:0]), .q(q_b), .ena(ena_b), .ovf(ovf_b), .bad_load(bad_b));

    bcd_counter_n #(.DIGITS(6), .WRAP(1'b1)) u_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .q(q_c), .ena(ena_c), .ovf(ovf_c), .bad_load(bad_c));

    typedef struct packed {
        logic [2:0][23:0] q;
        logic [2:0]       ovf;
        logic [2:0]       bad;
        logic [2:0][4:0]  ena;
    } exp_t;

    typedef struct packed {
        logic [23:0] q;
        logic        ovf;
        logic        bad;
    } st_t;

    exp_t sb[$];
    st_t  mdl [3];
    bit   known = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int nd(input int k);
        return (k == 2) ? 6 : 4;
    endfunction

    function automatic bit wr(input int k);
        return (k == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd2int(input logic [23:0] b, input int n);
        int v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [23:0] int2bcd(input int v, input int n);
        logic [23:0] r = 24'd0;
        int t = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal model of one clock edge.
    function automatic st_t mstep(input st_t s, input int n, input bit w,
                                  input bit r, input bit l, input bit e, input bit u,
                                  input logic [23:0] lv);
        st_t o;
        int v, mx;
        o.q = s.q; o.ovf = 1'b0; o.bad = 1'b0;
        if (r) begin
            o.q = 24'd0;
        end else if (l) begin
            o.q = 24'd0;
            for (int i = 0; i < n; i++) begin
                if (lv[4*i +: 4] > 4'd9) o.bad = 1'b1;
                else o.q[4*i +: 4] = lv[4*i +: 4];
            end
        end else if (e) begin
            v  = bcd2int(s.q, n);
            mx = pow10(n) - 1;
            if (u && v == mx) begin
                o.ovf = 1'b1; o.q = w ? 24'd0 : s.q;
            end else if (!u && v == 0) begin
                o.ovf = 1'b1; o.q = w ? int2bcd(mx, n) : s.q;
            end else begin
                o.q = int2bcd(u ? v + 1 : v - 1, n);
            end
        end
        return o;
    endfunction

    // Decimal model of the ripple enables for the current inputs.
    function automatic logic [4:0] mena(input st_t s, input int n, input bit w,
                                        input bit r, input bit l, input bit e, input bit u);
        logic [4:0] o = 5'd0;
        int v, m;
        bit term;
        if (r || l || !e) return o;
        v    = bcd2int(s.q, n);
        term = u ? (v == pow10(n) - 1) : (v == 0);
        if (term && !w) return o;
        for (int i = 1; i < n; i++) begin
            m = pow10(i);
            o[i-1] = u ? ((v % m) == m - 1) : ((v % m) == 0);
        end
        return o;
    endfunction

    // One stimulus cycle: drive inputs, queue expectations, advance models.
    task automatic cyc(input bit r, input bit l, input bit e, input bit u,
                       input logic [23:0] lv);
        exp_t x;
        @(negedge clk);
        reset = r; load = l; en = e; up = u; load_val = lv;
        if (known) begin
            for (int k = 0; k < 3; k++) begin
                x.q[k]   = mdl[k].q;
                x.ovf[k] = mdl[k].ovf;
                x.bad[k] = mdl[k].bad;
                x.ena[k] = mena(mdl[k], nd(k), wr(k), r, l, e, u);
            end
            sb.push_back(x);
        end
        for (int k = 0; k < 3; k++) mdl[k] = mstep(mdl[k], nd(k), wr(k), r, l, e, u, lv);
        if (r) known = 1'b1;
    endtask

    task automatic chk(input string nm, input int k, input logic [23:0] act,
                       input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[inst %0d] t=%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Monitor: every cycle after the inputs settle, compare against the queue.
    initial begin
        exp_t x;
        logic [2:0][23:0] aq;
        logic [2:0][4:0]  ae;
        logic [2:0]       ao, ab;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                aq[0] = {8'd0, q_a}; aq[1] = {8'd0, q_b}; aq[2] = q_c;
                ae[0] = {2'd0, ena_a}; ae[1] = {2'd0, ena_b}; ae[2] = ena_c;
                ao = {ovf_c, ovf_b, ovf_a};
                ab = {bad_c, bad_b, bad_a};
                for (int k = 0; k < 3; k++) begin
                    chk("q", k, aq[k], x.q[k]);
                    chk("ena", k, {19'd0, ae[k]}, {19'd0, x.ena[k]});
                    chk("ovf", k, {23'd0, ao[k]}, {23'd0, x.ovf[k]});
                    chk("bad_load", k, {23'd0, ab[k]}, {23'd0, x.bad[k]});
                end
            end
        end
    end

    // Directed vectors followed by a random soak.
    initial begin
        logic [23:0] lv;
        bit r, l, e, u;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 24'd0);
        repeat (12) cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
        // carry ripple through two digits
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h000998);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
        // terminal count up, then reverse direction without a gap
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h009999);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 24'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
        // terminal count down
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
        // bad nibble, load beating en, reset beating load
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h0012A4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 24'h000555);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 24'h004321);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(31) == 0);
            l  = ($urandom_range(7) == 0);
            e  = ($urandom_range(3) != 0);
            u  = 1'($urandom_range(1));
            lv = 24'($urandom);
            case ($urandom_range(3))
                0:       lv = 24'h999997;
                1:       lv = 24'h000002;
                default: lv = lv;
            endcase
            cyc(r, l, e, u, lv);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
        repeat (2) @(negedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
